// File: rtl/cpu_multi_cycle.sv
// Multi-cycle RV32I-subset core with a single unified req/ack memory port.
// Each instruction is sequenced by FETCH/DECODE/EXEC/MEM/WB; halt/fault status and cycle/retire counters.
module cpu_multi_cycle #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             halted,
  output logic             fault,
  output logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);
  localparam logic [31:0] HALT = 32'h0010_0073;
  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LOAD = 7'h03, OP_STORE = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63, OP_JAL = 7'h6F, OP_JALR = 7'h67;
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17;
  localparam int SH_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT} state_t;
  state_t state, state_next;

  logic [WIDTH-1:0] pc, ir, a, b, aluout, mdr;
  logic [WIDTH-1:0] rf [32];

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic       funct7_5;
  logic [WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [WIDTH-1:0] rs1_data, rs2_data, op_b, alu_y, exec_y, target;
  logic legal, is_store, is_load, is_branch, taken, misaligned;
  logic xfer, retire_next, rf_we;

  assign opcode   = ir[6:0];
  assign rd       = ir[11:7];
  assign funct3   = ir[14:12];
  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign funct7_5 = ir[30];
  assign imm_i = WIDTH'($signed(ir[31:20]));
  assign imm_s = WIDTH'($signed({ir[31:25], ir[11:7]}));
  assign imm_b = WIDTH'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
  assign imm_u = WIDTH'($signed({ir[31:12], 12'b0}));
  assign imm_j = WIDTH'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));

  assign is_store  = (opcode == OP_STORE);
  assign is_load   = (opcode == OP_LOAD);
  assign is_branch = (opcode == OP_BRANCH);
  assign rs1_data  = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rs2_data  = (rs2 == 5'd0) ? '0 : rf[rs2];
  assign xfer      = mem_req && mem_ack;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_JAL, OP_LUI, OP_AUIPC: legal = 1'b1;
      OP_JALR:           legal = (funct3 == 3'd0);
      OP_LOAD, OP_STORE: legal = (funct3 == 3'b010);
      OP_BRANCH:         legal = (funct3[2:1] != 2'b01);
      default:           legal = 1'b0;
    endcase
  end

  // Shared ALU for R and I types; SUB only exists in R form, SRA/SRAI both use bit 30.
  always_comb begin
    op_b = (opcode == OP_R) ? b : imm_i;
    case (funct3)
      3'd0:    alu_y = (opcode == OP_R && funct7_5) ? a - op_b : a + op_b;
      3'd1:    alu_y = a << op_b[SH_W-1:0];
      3'd2:    alu_y = WIDTH'($signed(a) < $signed(op_b));
      3'd3:    alu_y = WIDTH'(a < op_b);
      3'd4:    alu_y = a ^ op_b;
      3'd5:    alu_y = funct7_5 ? WIDTH'($signed(a) >>> op_b[SH_W-1:0]) : a >> op_b[SH_W-1:0];
      3'd6:    alu_y = a | op_b;
      default: alu_y = a & op_b;
    endcase
  end

  always_comb begin
    case (funct3)
      3'd0:    taken = (a == b);
      3'd1:    taken = (a != b);
      3'd4:    taken = ($signed(a) < $signed(b));
      3'd5:    taken = ($signed(a) >= $signed(b));
      3'd6:    taken = (a < b);
      default: taken = (a >= b);
    endcase
    case (opcode)
      OP_R, OP_I: exec_y = alu_y;
      OP_LOAD:    exec_y = a + imm_i;
      OP_STORE:   exec_y = a + imm_s;
      OP_LUI:     exec_y = imm_u;
      OP_AUIPC:   exec_y = pc + imm_u;
      default:    exec_y = pc + FOUR;
    endcase
    case (opcode)
      OP_BRANCH: target = taken ? pc + imm_b : pc + FOUR;
      OP_JAL:    target = pc + imm_j;
      OP_JALR:   target = (a + imm_i) & ~WIDTH'(1);
      default:   target = pc + FOUR;
    endcase
    misaligned = (is_load || is_store) ? (exec_y[1:0] != 2'b00) : target[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (xfer) state_next = (mem_rdata[31:0] == HALT) ? S_HALT : S_DECODE;
      S_DECODE: state_next = legal ? S_EXEC : S_FAULT;
      S_EXEC: begin
        if (misaligned)               state_next = S_FAULT;
        else if (is_branch)           state_next = S_FETCH;
        else if (is_load || is_store) state_next = S_MEM;
        else                          state_next = S_WB;
      end
      S_MEM:    if (xfer) state_next = is_store ? S_FETCH : S_WB;
      S_WB:     state_next = S_FETCH;
      default:  state_next = state;
    endcase
  end

  // Port outputs are decoded from state and gated by rst so a pending request drops at once.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    retire_next = 1'b0;
    rf_we       = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_addr = pc;
        end
        S_MEM: begin
          mem_req     = 1'b1;
          mem_addr    = aluout;
          mem_we      = is_store;
          mem_wdata   = is_store ? b : '0;
          retire_next = is_store && mem_ack;
        end
        S_EXEC: retire_next = is_branch && !misaligned;
        S_WB: begin
          rf_we       = (rd != 5'd0);
          retire_next = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      ir          <= '0;
      a           <= '0;
      b           <= '0;
      aluout      <= '0;
      mdr         <= '0;
      retire      <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      retire    <= retire_next;
      halted    <= (state == S_HALT);
      fault     <= (state == S_FAULT);
      if (retire_next) instret_cnt <= instret_cnt + 1'b1;
      case (state)
        S_FETCH: if (xfer) ir <= mem_rdata;
        S_DECODE: begin
          a <= rs1_data;
          b <= rs2_data;
        end
        S_EXEC: begin
          aluout <= exec_y;
          if (!misaligned && !is_load && !is_store) pc <= target;
        end
        S_MEM: if (xfer) begin
          pc <= pc + FOUR;
          if (!is_store) mdr <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rf_we) rf[rd] <= is_load ? mdr : aluout;
  end
endmodule

// File: tb/tb_cpu_multi_cycle.sv
// Scoreboard bench for cpu_multi_cycle: expected memory transfers and retire latencies are queued
// by the directed tests and popped by independent monitors on the memory port and retire pulse.
module tb_cpu_multi_cycle;
  localparam logic [31:0] HALT = 32'h0010_0073;

  logic        clk, rst, mem_req, mem_we, mem_ack, halted, fault, retire;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, cycle_cnt, instret_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cpu_multi_cycle #(.WIDTH(32), .RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .halted(halted),
    .fault(fault), .retire(retire), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} txn_t;
  txn_t        exp_txn[$];
  int          exp_lat[$];
  logic [31:0] mem [256];
  int          checks = 0, errors = 0, wait_states = 0, wcnt, retire_seen = 0;
  logic        block_en = 1'b0;
  logic [31:0] block_addr = 32'h0, last_cyc = 32'h0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got 0x%08h want 0x%08h", name, got, want);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [6:0] op, input int f3, rd, rs1, input logic [31:0] imm);
    return {imm[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_r(input int f7, rs2, rs1, f3, rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input int rs2, rs1, input logic [31:0] imm);
    return {imm[11:5], 5'(rs2), 5'(rs1), 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input int f3, rs1, rs2, input logic [31:0] imm);
    return {imm[12], imm[10:5], 5'(rs2), 5'(rs1), 3'(f3), imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [6:0] op, input int rd, input logic [31:0] imm);
    return {imm[31:12], 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_j(input int rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'(rd), 7'h6F};
  endfunction

  // Memory model with a programmable number of wait states; logs every completed transfer.
  always @(negedge clk) begin
    txn_t t;
    if (rst || !mem_req) begin
      mem_ack <= 1'b0;
      wcnt    <= 0;
    end else if (block_en && mem_addr == block_addr) begin
      mem_ack <= 1'b0;
    end else if (wcnt >= wait_states) begin
      mem_ack   <= 1'b1;
      wcnt      <= 0;
      mem_rdata <= mem[mem_addr[9:2]];
      if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
      if (exp_txn.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL txn_unexpected got we=%0d addr=0x%08h want no transfer", mem_we, mem_addr);
      end else begin
        t = exp_txn.pop_front();
        check("txn_we", 32'(mem_we), 32'(t.we));
        check("txn_addr", mem_addr, t.addr);
        if (t.we) check("txn_wdata", mem_wdata, t.data);
      end
    end else begin
      mem_ack <= 1'b0;
      wcnt    <= wcnt + 1;
    end
  end

  // Retire monitor: cycle_cnt delta between retire pulses is the instruction latency.
  always @(negedge clk) begin
    if (rst) begin
      retire_seen = 0;
      last_cyc    = 32'h0;
    end else if (retire) begin
      retire_seen++;
      if (exp_lat.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL retire_unexpected got retire at cycle %0d want none", cycle_cnt);
      end else begin
        check("retire_latency", cycle_cnt - last_cyc, 32'(exp_lat.pop_front()));
      end
      last_cyc = cycle_cnt;
    end
  end

  task automatic exp_rd(input logic [31:0] addr);
    exp_txn.push_back(txn_t'{we: 1'b0, addr: addr, data: 32'h0});
  endtask
  task automatic exp_wr(input logic [31:0] addr, input logic [31:0] data);
    exp_txn.push_back(txn_t'{we: 1'b1, addr: addr, data: data});
  endtask
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask
  task automatic put(input int addr, input logic [31:0] w);
    mem[addr / 4] = w;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("restart_req", 32'(mem_req), 32'd1);
    check("restart_addr", mem_addr, 32'h0);
  endtask

  task automatic run_prog(input string name, input int ws, input bit want_halt,
                          input int want_ret, input int want_cyc);
    int n;
    wait_states = ws;
    release_rst();
    n = 0;
    while (!halted && !fault && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got no halt/fault want stop within 3000 cycles", name);
    end
    check({name, "_halted"}, 32'(halted), 32'(want_halt));
    check({name, "_fault"}, 32'(fault), 32'(!want_halt));
    check({name, "_cycles"}, cycle_cnt, 32'(want_cyc));
    check({name, "_instret"}, instret_cnt, 32'(want_ret));
    check({name, "_retires"}, 32'(retire_seen), 32'(want_ret));
    repeat (4) @(negedge clk);
    check({name, "_req_idle"}, 32'(mem_req), 32'd0);
    check({name, "_txn_left"}, 32'(exp_txn.size()), 32'd0);
    check({name, "_lat_left"}, 32'(exp_lat.size()), 32'd0);
    exp_txn.delete();
    exp_lat.delete();
    #1 rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_flags", {29'b0, halted, fault, retire}, 32'h0);
    check("rst_cycle", cycle_cnt, 32'h0);
    check("rst_instret", instret_cnt, 32'h0);

    // Arithmetic with 3 wait states: each ALU op is 4+3 cycles, HALT fetch 4, +1 for halted.
    clear_mem();
    put(32'h0, enc_i(7'h13, 0, 1, 0, 5));
    put(32'h4, enc_i(7'h13, 0, 2, 0, -3));
    put(32'h8, enc_r(0, 2, 1, 0, 3));
    put(32'hC, HALT);
    exp_rd(32'h0); exp_rd(32'h4); exp_rd(32'h8); exp_rd(32'hC);
    exp_lat = '{7, 7, 7};
    run_prog("arith", 3, 1'b1, 3, 26);
    check("arith_x1", dut.rf[1], 32'd5);
    check("arith_x2", dut.rf[2], 32'hFFFF_FFFD);
    check("arith_x3", dut.rf[3], 32'd2);

    // Store/load round trip at zero wait.
    clear_mem();
    put(32'h0, enc_u(7'h37, 1, 32'hDEAD_C000));
    put(32'h4, enc_i(7'h13, 0, 1, 1, -273));
    put(32'h8, enc_s(1, 0, 8));
    put(32'hC, enc_i(7'h03, 2, 4, 0, 8));
    put(32'h10, HALT);
    exp_rd(32'h0); exp_rd(32'h4); exp_rd(32'h8); exp_wr(32'h8, 32'hDEAD_BEEF);
    exp_rd(32'hC); exp_rd(32'h8); exp_rd(32'h10);
    exp_lat = '{4, 4, 4, 5};
    run_prog("ldst", 0, 1'b1, 4, 19);
    check("ldst_x4", dut.rf[4], 32'hDEAD_BEEF);

    // Branches: BLT taken, BLTU not taken, BGEU taken.
    clear_mem();
    put(32'h0, enc_i(7'h13, 0, 1, 0, -1));
    put(32'h4, enc_i(7'h13, 0, 2, 0, 1));
    put(32'h8, enc_b(4, 1, 2, 8));
    put(32'hC, HALT);
    put(32'h10, enc_b(6, 1, 2, 8));
    put(32'h14, enc_i(7'h13, 0, 2, 0, -1));
    put(32'h18, enc_b(7, 1, 2, 8));
    put(32'h1C, HALT);
    put(32'h20, HALT);
    exp_rd(32'h0); exp_rd(32'h4); exp_rd(32'h8); exp_rd(32'h10);
    exp_rd(32'h14); exp_rd(32'h18); exp_rd(32'h20);
    exp_lat = '{4, 4, 3, 3, 4, 3};
    run_prog("branch", 0, 1'b1, 6, 23);

    // Jumps with 1 wait state; JALR target 0x26 is misaligned.
    clear_mem();
    put(32'h0, enc_i(7'h13, 0, 6, 0, 32'h55));
    put(32'h4, enc_j(0, 32'h1C));
    put(32'h20, enc_j(5, 16));
    put(32'h30, enc_i(7'h67, 0, 6, 5, 3));
    exp_rd(32'h0); exp_rd(32'h4); exp_rd(32'h20); exp_rd(32'h30);
    exp_lat = '{5, 5, 5};
    run_prog("jump", 1, 1'b0, 3, 20);
    check("jump_x5", dut.rf[5], 32'h24);
    check("jump_x6", dut.rf[6], 32'h55);

    // x0 is never written; then an illegal opcode faults.
    clear_mem();
    put(32'h0, enc_i(7'h13, 0, 0, 0, 7));
    put(32'h4, enc_s(0, 0, 32'h80));
    put(32'h8, 32'h0000_007F);
    exp_rd(32'h0); exp_rd(32'h4); exp_wr(32'h80, 32'h0); exp_rd(32'h8);
    exp_lat = '{4, 4};
    run_prog("illegal", 0, 1'b0, 2, 11);

    // Misaligned load faults in EXEC without any data request.
    clear_mem();
    put(32'h0, enc_i(7'h03, 2, 7, 0, 6));
    exp_rd(32'h0);
    run_prog("misload", 2, 1'b0, 0, 6);

    // Asynchronous reset while a load waits in MEM.
    clear_mem();
    put(32'h0, enc_i(7'h03, 2, 1, 0, 32'h40));
    block_en    = 1'b1;
    block_addr  = 32'h40;
    wait_states = 0;
    for (int pass = 0; pass < 2; pass++) begin
      exp_rd(32'h0);
      release_rst();
      n = 0;
      while (!(mem_req && mem_addr == 32'h40) && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("arst_mem_phase_cycle", cycle_cnt, 32'd3);
      check("arst_mem_we", 32'(mem_we), 32'd0);
      #1 rst = 1'b1;
      #1;
      check("arst_req_drop", 32'(mem_req), 32'd0);
      check("arst_cycle_clear", cycle_cnt, 32'h0);
      check("arst_txn_left", 32'(exp_txn.size()), 32'd0);
      exp_txn.delete();
      @(negedge clk);
    end
    block_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_multi_cycle.md
# cpu_multi_cycle

Parametrised multi-cycle RV32I-subset core, successor to the single-cycle core. It replaces the internal instruction/data memories with one external unified memory port using a req/ack handshake, so the memory may insert any number of wait states. A controller FSM sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB, and the block provides halt/fault status and cycle/retire counters. It reuses the codebase's `decoder`, `regfile`, `alu` and `alu_ctrl` blocks and the `all_pkgs` opcode and `HALT` constants.

## Interface
- `WIDTH`, default 32: datapath and address width.
- `RESET_PC`, default 0: PC value loaded on reset; must be word aligned.
- `CNT_W`, default 32: width of the cycle and retire counters.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `mem_req`, output, 1: memory request valid.
- `mem_we`, output, 1: 1 = store, 0 = read (fetch or load).
- `mem_addr`, output, `WIDTH`: byte address, word aligned.
- `mem_wdata`, output, `WIDTH`: store data (rs2).
- `mem_rdata`, input, `WIDTH`: read data; valid in the cycle `mem_ack`=1.
- `mem_ack`, input, 1: transfer completes on an edge where `mem_req` and `mem_ack` are both 1.
- `halted`, output, 1: core stopped on a `HALT` instruction.
- `fault`, output, 1: core stopped on an illegal opcode or a misaligned address.
- `retire`, output, 1: one-cycle pulse when an instruction completes.
- `cycle_cnt`, output, `CNT_W`: free-running cycle count since reset.
- `instret_cnt`, output, `CNT_W`: count of retired instructions.

## Operation
- **Supported instructions:** R-type ALU, I-type ALU, LW, SW, BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR, LUI, AUIPC, and `HALT`.
- **Internal registers:** PC, IR, A, B (latched regfile reads), ALUOUT and MDR.
- **FETCH:** `mem_req`=1, `mem_we`=0, `mem_addr`=PC. On ack, IR<=`mem_rdata` and go to DECODE. If IR==`HALT`, go to HALT instead, with no retire.
- **DECODE:**
  - A<=rs1 data, B<=rs2 data.
  - Unknown opcode: go to FAULT.
  - Otherwise go to EXEC.
- **EXEC:** ALUOUT<=ALU result.
  - The ALU B operand is the immediate for I, S, load and JALR, otherwise B.
  - LUI computes 0+imm_u; AUIPC computes PC+imm_u.
  - Branches: compare A and B signed or unsigned per funct3. PC<=taken ? PC+imm_b : PC+4, then retire and go to FETCH.
  - JAL sets PC<=PC+imm_j; JALR sets PC<=(A+imm_i)&~1. In both cases ALUOUT<=PC+4.
  - Load/store: go to MEM. If the effective address has bits[1:0]!=0, go to FAULT.
  - All other instructions: PC<=PC+4, go to WB. JAL/JALR also go to WB.
- **MEM:** `mem_req`=1, `mem_addr`=ALUOUT, `mem_we`=store, `mem_wdata`=B.
  - On ack, a store sets PC<=PC+4, retires and goes to FETCH.
  - On ack, a load sets MDR<=`mem_rdata` and goes to WB.
- **WB:** regfile write rd<=(load ? MDR : ALUOUT), then retire and go to FETCH. Writes to x0 are discarded by `regfile`.
- **HALT / FAULT:** terminal states. `mem_req`=0 and no register writes. `cycle_cnt` keeps counting. Only reset exits.
- **FETCH address check:** in the reachable design PC is always aligned, since all targets are computed word aligned. A misaligned jump target (bit1 set) goes to FAULT at EXEC.
- **Counters:** increment modulo 2^`CNT_W` and wrap to 0 without a flag. `instret_cnt` increments in the `retire` cycle.

## Timing
- **Reset values:**
  - State=FETCH, PC=`RESET_PC`, IR/A/B/ALUOUT/MDR=0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `halted`=0, `fault`=0, `retire`=0, counters=0.
  - `mem_req` asserts in the first cycle after `rst` deasserts.
- **Handshake:**
  - While `mem_req`=1, `mem_addr`, `mem_we` and `mem_wdata` are held stable until the ack edge.
  - `mem_req` drops in the cycle after ack unless the next state issues a new request. MEM→FETCH passes through no idle cycle, so req stays high with a new address.
  - `mem_ack` while `mem_req`=0 is ignored.
- **Latency with zero wait (ack in the first request cycle):** ALU, LUI, AUIPC, JAL and JALR take 4 cycles; LW takes 5; SW takes 4; branches take 3. Each wait cycle adds 1 per memory access.
- `retire` is registered and pulses in the cycle after the final state of the instruction.
- `halted` and `fault` are registered and rise one cycle after entry to the terminal state. `retire` never pulses for `HALT` or for the faulting instruction.
- **Async reset mid-transfer:** `mem_req` drops immediately (asynchronously). A pending transfer is abandoned, and the memory must tolerate this.
- Reads from the regfile are combinational and the write occurs at the WB edge. A following instruction reading the same register sees the new value.

## Test plan
- **Arithmetic, 3 wait states on all accesses:** `addi x1,x0,5`; `addi x2,x0,-3`; `add x3,x1,x2`; `HALT` -> x3=2; `instret_cnt`=3; `halted`=1, `fault`=0; `cycle_cnt` equals the sum of the per-instruction latencies.
- **Store/load round trip:** `sw x1,8(x0)` then `lw x4,8(x0)` with x1=0xDEADBEEF -> one write req at address 8 with wdata 0xDEADBEEF; x4=0xDEADBEEF; the load takes 5 cycles at zero wait.
- **Branches:** BLT with x1=-1, x2=1 is taken; BLTU on the same values is not taken; BGEU with x1=x2 is taken -> PC follows the expected targets; each branch takes 3 cycles at zero wait.
- **Jumps:** `jal x5,+16` at PC 0x20 -> x5=0x24, next fetch at 0x30. `jalr x6,3(x5)` -> next fetch at 0x26, which is misaligned, so FAULT with `fault`=1 and no retire.
- **Faults and x0:** illegal opcode 0x0000007F -> `fault`=1, `mem_req`=0 thereafter. `lw` at address 0x6 -> `fault`, with no memory request issued. `addi x0,x0,7` -> x0 stays 0.
- **Async reset:** assert `rst` mid-MEM with `mem_ack` held low -> `mem_req`=0 in the same cycle; after release, fetch restarts at `RESET_PC` and counters restart from 0.
